// File: rtl/pix_frame_ctrl.sv
// Pixel frame capture controller: register bus, RUN/DONE sequencing,
// a small output buffer for processed pixels and a frame-done interrupt.
module pix_frame_ctrl #(
    parameter int unsigned FRAME_PIXELS = 1024,
    parameter int unsigned OBUF_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        bus_sel,
    input  logic [3:0]  bus_addr,
    input  logic [3:0]  bus_wstrb,
    input  logic [31:0] bus_wdata,
    output logic [31:0] bus_rdata,
    input  logic        proc_valid,
    input  logic [7:0]  proc_pixel,
    input  logic        proc_status,
    output logic        src_ready,
    output logic [1:0]  cfg_mode,
    output logic        irq_frame
);

    localparam int AW = (OBUF_DEPTH > 1) ? $clog2(OBUF_DEPTH) : 1;
    localparam int LW = AW + 1;
    localparam logic [15:0]   FRAME_CNT = 16'(FRAME_PIXELS);
    localparam logic [LW-1:0] DEPTH_L   = LW'(OBUF_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [15:0]   count_q, count_d;
    logic          done_q, done_d;
    logic          ovf_q, ovf_d;
    logic [1:0]    mode_q, mode_d;
    logic          irq_en_q, irq_en_d;
    logic          irq_q;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic [7:0]    mem_q [OBUF_DEPTH];

    logic          wr_en, rd_en;
    logic          ctrl_wr, stat_wr, data_rd;
    logic          full, empty;
    logic          pop, accept, push, drop;
    logic          flush;
    logic [15:0]   cnt_inc;
    logic [3:0]    lvl_nib;
    logic          unused_wdata;

    assign unused_wdata = ^bus_wdata[31:5];

    // Bus decode: any nonzero strobe marks a write.
    assign wr_en   = bus_sel & (|bus_wstrb);
    assign rd_en   = bus_sel & ~(|bus_wstrb);
    assign ctrl_wr = wr_en & (bus_addr == 4'h0);
    assign stat_wr = wr_en & (bus_addr == 4'h4);
    assign data_rd = rd_en & (bus_addr == 4'h8);

    assign full  = (level_q == DEPTH_L);
    assign empty = (level_q == '0);

    // A pop frees a slot in the same cycle, so a full-buffer push still lands.
    assign pop     = data_rd & ~empty;
    assign accept  = (state_q == S_RUN) & proc_valid & proc_status;
    assign push    = accept & (~full | pop);
    assign drop    = accept & full & ~pop;
    assign cnt_inc = count_q + 16'd1;

    assign src_ready = (state_q == S_RUN) & ~full;
    assign cfg_mode  = mode_q;
    assign irq_frame = irq_q;

    assign lvl_nib = (32'(level_q) > 32'd15) ? 4'hF : 4'(level_q);

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        done_d   = done_q;
        ovf_d    = ovf_q;
        mode_d   = mode_q;
        irq_en_d = irq_en_q;
        flush    = 1'b0;

        if (stat_wr && bus_wdata[3]) begin
            ovf_d = 1'b0;
        end
        if (drop) begin
            ovf_d = 1'b1;
        end

        if (stat_wr && bus_wdata[2]) begin
            done_d = 1'b0;
            if (state_q == S_DONE) begin
                state_d = S_IDLE;
            end
        end

        if (accept) begin
            count_d = cnt_inc;
            if (cnt_inc == FRAME_CNT) begin
                state_d = S_DONE;
                done_d  = 1'b1;
            end
        end

        // Abort outranks a start carried in the same write.
        if (ctrl_wr) begin
            mode_d   = bus_wdata[3:2];
            irq_en_d = bus_wdata[4];
            if (bus_wdata[1]) begin
                if (state_q != S_IDLE) begin
                    state_d = S_IDLE;
                    flush   = 1'b1;
                end
            end else if (bus_wdata[0] && (state_q != S_RUN)) begin
                state_d = S_RUN;
                count_d = '0;
                done_d  = 1'b0;
            end
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_comb begin
        bus_rdata = '0;
        if (bus_sel) begin
            unique case (bus_addr)
                4'h0: bus_rdata = {27'b0, irq_en_q, mode_q, 2'b00};
                4'h4: bus_rdata = {24'b0, lvl_nib, ovf_q, done_q,
                                   state_q};
                4'h8: begin
                    if (!empty) begin
                        bus_rdata = {23'b0, 1'b1, mem_q[rd_ptr_q]};
                    end
                end
                4'hC: bus_rdata = {16'b0, count_q};
                default: bus_rdata = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
            mode_q   <= 2'b00;
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            done_q   <= done_d;
            ovf_q    <= ovf_d;
            mode_q   <= mode_d;
            irq_en_q <= irq_en_d;
            irq_q    <= done_d & irq_en_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: the level counter gates every read.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem_q[wr_ptr_q] <= proc_pixel;
        end
    end

endmodule

// File: tb/tb_pix_frame_ctrl.sv
// Directed bench for pix_frame_ctrl with FRAME_PIXELS=8, OBUF_DEPTH=4.
module tb_pix_frame_ctrl;

    logic        clk;
    logic        rstn;
    logic        bus_sel;
    logic [3:0]  bus_addr;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        proc_valid;
    logic [7:0]  proc_pixel;
    logic        proc_status;
    logic        src_ready;
    logic [1:0]  cfg_mode;
    logic        irq_frame;

    int pass_cnt;
    int total_cnt;

    pix_frame_ctrl #(
        .FRAME_PIXELS(8),
        .OBUF_DEPTH(4)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .bus_sel(bus_sel),
        .bus_addr(bus_addr),
        .bus_wstrb(bus_wstrb),
        .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata),
        .proc_valid(proc_valid),
        .proc_pixel(proc_pixel),
        .proc_status(proc_status),
        .src_ready(src_ready),
        .cfg_mode(cfg_mode),
        .irq_frame(irq_frame)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic bus_wr(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        bus_sel   = 1'b1;
        bus_addr  = a;
        bus_wstrb = 4'hF;
        bus_wdata = d;
        @(negedge clk);
        bus_sel   = 1'b0;
        bus_wstrb = 4'h0;
        bus_wdata = '0;
    endtask

    task automatic bus_rd(input logic [3:0] a, output logic [31:0] d);
        @(negedge clk);
        bus_sel   = 1'b1;
        bus_addr  = a;
        bus_wstrb = 4'h0;
        #1 d = bus_rdata;
        @(negedge clk);
        bus_sel = 1'b0;
    endtask

    task automatic pix(input logic [7:0] p, input logic st);
        @(negedge clk);
        proc_valid  = 1'b1;
        proc_pixel  = p;
        proc_status = st;
        @(negedge clk);
        proc_valid  = 1'b0;
        proc_status = 1'b0;
    endtask

    task automatic test_reset;
        logic [31:0] d;
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        total_cnt++;
        if (src_ready !== 1'b0 || cfg_mode !== 2'b00 || irq_frame !== 1'b0)
            $display("FAIL reset_out: got rdy=%b mode=%b irq=%b want 0 0 0",
                     src_ready, cfg_mode, irq_frame);
        else pass_cnt++;
        bus_rd(4'h4, d);
        total_cnt++;
        if (d !== 32'h0) $display("FAIL reset_status: got %h want 0", d);
        else pass_cnt++;
        bus_rd(4'hC, d);
        total_cnt++;
        if (d !== 32'h0) $display("FAIL reset_count: got %h want 0", d);
        else pass_cnt++;
        bus_rd(4'h0, d);
        total_cnt++;
        if (d !== 32'h0) $display("FAIL reset_ctrl: got %h want 0", d);
        else pass_cnt++;
    endtask

    task automatic test_frame;
        logic [31:0] d;
        bus_wr(4'h0, 32'h11);
        total_cnt++;
        if (src_ready !== 1'b1 || cfg_mode !== 2'b00)
            $display("FAIL frame_start: got rdy=%b mode=%b want 1 0",
                     src_ready, cfg_mode);
        else pass_cnt++;
        for (int i = 0; i < 8; i++) begin
            pix(8'(8'h10 + i), 1'b1);
            bus_rd(4'h8, d);
            total_cnt++;
            if (d !== 32'h110 + 32'(i))
                $display("FAIL frame_data%0d: got %h want %h",
                         i, d, 32'h110 + 32'(i));
            else pass_cnt++;
        end
        bus_rd(4'h4, d);
        total_cnt++;
        if (d !== 32'h6) $display("FAIL frame_status: got %h want 6", d);
        else pass_cnt++;
        bus_rd(4'hC, d);
        total_cnt++;
        if (d !== 32'h8) $display("FAIL frame_count: got %h want 8", d);
        else pass_cnt++;
        total_cnt++;
        if (irq_frame !== 1'b1 || src_ready !== 1'b0)
            $display("FAIL frame_irq: got irq=%b rdy=%b want 1 0",
                     irq_frame, src_ready);
        else pass_cnt++;
        bus_rd(4'h0, d);
        total_cnt++;
        if (d !== 32'h10) $display("FAIL frame_ctrl: got %h want 10", d);
        else pass_cnt++;
    endtask

    task automatic test_status_clear;
        logic [31:0] d;
        bus_wr(4'h4, 32'h4);
        total_cnt++;
        if (irq_frame !== 1'b0)
            $display("FAIL clr_irq: got %b want 0", irq_frame);
        else pass_cnt++;
        bus_rd(4'h4, d);
        total_cnt++;
        if (d !== 32'h0) $display("FAIL clr_status: got %h want 0", d);
        else pass_cnt++;
        bus_rd(4'h8, d);
        total_cnt++;
        if (d !== 32'h0) $display("FAIL empty_data: got %h want 0", d);
        else pass_cnt++;
    endtask

    task automatic test_overflow;
        logic [31:0] d;
        logic        exp_rdy;
        bus_wr(4'h0, 32'h01);
        for (int i = 0; i < 6; i++) begin
            pix(8'(8'hA0 + i), 1'b1);
            exp_rdy = (i < 3);
            total_cnt++;
            if (src_ready !== exp_rdy)
                $display("FAIL ovf_rdy%0d: got %b want %b",
                         i, src_ready, exp_rdy);
            else pass_cnt++;
        end
        bus_rd(4'h4, d);
        total_cnt++;
        if (d !== 32'h49) $display("FAIL ovf_status: got %h want 49", d);
        else pass_cnt++;
        bus_rd(4'hC, d);
        total_cnt++;
        if (d !== 32'h6) $display("FAIL ovf_count: got %h want 6", d);
        else pass_cnt++;
    endtask

    task automatic test_pop_push_full;
        logic [31:0] d;
        logic [31:0] exp_q [4];
        exp_q[0] = 32'h1A1;
        exp_q[1] = 32'h1A2;
        exp_q[2] = 32'h1A3;
        exp_q[3] = 32'h1B0;
        bus_wr(4'h4, 32'h8);
        bus_rd(4'h4, d);
        total_cnt++;
        if (d !== 32'h41) $display("FAIL ovf_clear: got %h want 41", d);
        else pass_cnt++;
        @(negedge clk);
        bus_sel     = 1'b1;
        bus_addr    = 4'h8;
        bus_wstrb   = 4'h0;
        proc_valid  = 1'b1;
        proc_pixel  = 8'hB0;
        proc_status = 1'b1;
        #1 d = bus_rdata;
        @(negedge clk);
        bus_sel     = 1'b0;
        proc_valid  = 1'b0;
        proc_status = 1'b0;
        total_cnt++;
        if (d !== 32'h1A0) $display("FAIL pp_head: got %h want 1a0", d);
        else pass_cnt++;
        bus_rd(4'h4, d);
        total_cnt++;
        if (d !== 32'h41) $display("FAIL pp_status: got %h want 41", d);
        else pass_cnt++;
        bus_rd(4'hC, d);
        total_cnt++;
        if (d !== 32'h7) $display("FAIL pp_count: got %h want 7", d);
        else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            bus_rd(4'h8, d);
            total_cnt++;
            if (d !== exp_q[i])
                $display("FAIL drain%0d: got %h want %h", i, d, exp_q[i]);
            else pass_cnt++;
        end
        bus_rd(4'h4, d);
        total_cnt++;
        if (d !== 32'h1) $display("FAIL drain_status: got %h want 1", d);
        else pass_cnt++;
    endtask

    task automatic test_start_ignored;
        logic [31:0] d;
        bus_wr(4'h0, 32'h0D);
        bus_rd(4'hC, d);
        total_cnt++;
        if (d !== 32'h7 || cfg_mode !== 2'b11)
            $display("FAIL run_start: got cnt=%h mode=%b want 7 11",
                     d, cfg_mode);
        else pass_cnt++;
        bus_wr(4'h0, 32'h0F);
        bus_rd(4'h4, d);
        total_cnt++;
        if (d !== 32'h0 || cfg_mode !== 2'b11)
            $display("FAIL abort_wins: got st=%h mode=%b want 0 11",
                     d, cfg_mode);
        else pass_cnt++;
    endtask

    task automatic test_warmup;
        logic [31:0] d;
        bus_wr(4'h0, 32'h01);
        for (int i = 0; i < 3; i++) pix(8'(8'h50 + i), 1'b0);
        bus_rd(4'hC, d);
        total_cnt++;
        if (d !== 32'h0) $display("FAIL warm_count0: got %h want 0", d);
        else pass_cnt++;
        pix(8'h60, 1'b1);
        bus_rd(4'hC, d);
        total_cnt++;
        if (d !== 32'h1) $display("FAIL warm_count1: got %h want 1", d);
        else pass_cnt++;
        bus_rd(4'h4, d);
        total_cnt++;
        if (d !== 32'h11) $display("FAIL warm_status: got %h want 11", d);
        else pass_cnt++;
    endtask

    task automatic test_abort;
        logic [31:0] d;
        pix(8'h61, 1'b1);
        bus_wr(4'h0, 32'h03);
        total_cnt++;
        if (src_ready !== 1'b0)
            $display("FAIL abort_rdy: got %b want 0", src_ready);
        else pass_cnt++;
        bus_rd(4'h4, d);
        total_cnt++;
        if (d !== 32'h0) $display("FAIL abort_status: got %h want 0", d);
        else pass_cnt++;
        bus_rd(4'h8, d);
        total_cnt++;
        if (d !== 32'h0) $display("FAIL abort_data: got %h want 0", d);
        else pass_cnt++;
        pix(8'h70, 1'b1);
        bus_rd(4'hC, d);
        total_cnt++;
        if (d !== 32'h2) $display("FAIL idle_ignore: got %h want 2", d);
        else pass_cnt++;
    endtask

    task automatic test_reset_midframe;
        logic [31:0] d;
        bus_wr(4'h0, 32'h1D);
        for (int i = 0; i < 5; i++) pix(8'(8'h80 + i), 1'b1);
        bus_rd(4'hC, d);
        total_cnt++;
        if (d !== 32'h5) $display("FAIL mid_count: got %h want 5", d);
        else pass_cnt++;
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        total_cnt++;
        if (src_ready !== 1'b0 || cfg_mode !== 2'b00 || irq_frame !== 1'b0)
            $display("FAIL mid_out: got rdy=%b mode=%b irq=%b want 0 0 0",
                     src_ready, cfg_mode, irq_frame);
        else pass_cnt++;
        bus_rd(4'h4, d);
        total_cnt++;
        if (d !== 32'h0) $display("FAIL mid_status: got %h want 0", d);
        else pass_cnt++;
        bus_rd(4'hC, d);
        total_cnt++;
        if (d !== 32'h0) $display("FAIL mid_cnt0: got %h want 0", d);
        else pass_cnt++;
        bus_rd(4'h0, d);
        total_cnt++;
        if (d !== 32'h0) $display("FAIL mid_ctrl: got %h want 0", d);
        else pass_cnt++;
        bus_rd(4'h8, d);
        total_cnt++;
        if (d !== 32'h0) $display("FAIL mid_data: got %h want 0", d);
        else pass_cnt++;
    endtask

    initial begin
        pass_cnt    = 0;
        total_cnt   = 0;
        rstn        = 1'b1;
        bus_sel     = 1'b0;
        bus_addr    = 4'h0;
        bus_wstrb   = 4'h0;
        bus_wdata   = '0;
        proc_valid  = 1'b0;
        proc_pixel  = 8'h00;
        proc_status = 1'b0;
        test_reset();
        test_frame();
        test_status_clear();
        test_overflow();
        test_pop_push_full();
        test_start_ignored();
        test_warmup();
        test_abort();
        test_reset_midframe();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
